fetch: RTL and testbench

- Instruction fetch stage of the in-order RV32I pipeline.
- Sits in front of decode: supplies INSTR/VALID to decode and consumes decode's STALLED (as NEXT_STALLED) and its BRANCH/BRANCH_IMM redirect.
- Owns the PC and a single-outstanding req/ack port to instruction memory.
- On a redirect it squashes the held instruction and any in-flight fetch, then restarts at the branch target.

---
 rtl/fetch.sv | 189 ++++++++++++++++++
 tb/tb_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// RV32I fetch stage: owns the PC and drives one outstanding imem request at a time.
// ACK-to-VALID is one cycle; INSTR is held until decode accepts it or a redirect squashes it.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  output logic        VALID,
  input  logic        NEXT_STALLED,
  input  logic        BRANCH,
  input  logic [11:0] BRANCH_IMM,
  output logic        MISALIGN
);

  typedef logic [31:0] instr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DROP,
    S_HOLD,
    S_HALT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] acc_pc, acc_pc_nxt;
  logic        req_nxt;
  logic [31:0] addr_nxt;
  instr_t      instr_nxt;
  logic [31:0] instr_pc_nxt;
  logic        valid_nxt;
  logic        mis_nxt;

  logic        accept;
  logic [31:0] offset;
  logic [31:0] target;
  logic        tgt_mis;
  logic [31:0] pend;

  assign accept  = VALID && !NEXT_STALLED;
  // BRANCH_IMM counts halfwords, so the byte offset is imm*2 sign-extended.
  assign offset  = {{19{BRANCH_IMM[11]}}, BRANCH_IMM, 1'b0};
  assign target  = acc_pc + offset;
  assign tgt_mis = (target[1:0] != 2'b00);
  // Inside the drop window the latest redirect wins over the one already parked in pc.
  assign pend    = BRANCH ? target : pc;

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    acc_pc_nxt   = accept ? INSTR_PC : acc_pc;
    req_nxt      = IMEM_REQ;
    addr_nxt     = IMEM_ADDR;
    instr_nxt    = INSTR;
    instr_pc_nxt = INSTR_PC;
    valid_nxt    = VALID;
    mis_nxt      = MISALIGN;

    case (state)
      S_IDLE: begin
        if (BRANCH && tgt_mis) begin
          state_nxt = S_HALT;
          mis_nxt   = 1'b1;
          req_nxt   = 1'b0;
          valid_nxt = 1'b0;
        end else if (BRANCH) begin
          pc_nxt    = target;
          req_nxt   = 1'b1;
          addr_nxt  = target;
          state_nxt = S_FETCH;
        end else begin
          req_nxt   = 1'b1;
          addr_nxt  = pc;
          state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        if (IMEM_ACK && BRANCH) begin
          if (tgt_mis) begin
            state_nxt = S_HALT;
            mis_nxt   = 1'b1;
            req_nxt   = 1'b0;
            valid_nxt = 1'b0;
          end else begin
            pc_nxt   = target;
            req_nxt  = 1'b1;
            addr_nxt = target;
          end
        end else if (IMEM_ACK) begin
          instr_nxt    = IMEM_RDATA;
          instr_pc_nxt = IMEM_ADDR;
          valid_nxt    = 1'b1;
          pc_nxt       = pc + 32'd4;
          req_nxt      = 1'b0;
          state_nxt    = S_HOLD;
        end else if (BRANCH) begin
          // The request must stay up at its old address until memory answers.
          pc_nxt    = target;
          state_nxt = S_DROP;
        end
      end

      S_DROP: begin
        pc_nxt = pend;
        if (IMEM_ACK) begin
          if (pend[1:0] != 2'b00) begin
            state_nxt = S_HALT;
            mis_nxt   = 1'b1;
            req_nxt   = 1'b0;
            valid_nxt = 1'b0;
          end else begin
            req_nxt   = 1'b1;
            addr_nxt  = pend;
            state_nxt = S_FETCH;
          end
        end
      end

      S_HOLD: begin
        if (BRANCH) begin
          valid_nxt = 1'b0;
          if (tgt_mis) begin
            state_nxt = S_HALT;
            mis_nxt   = 1'b1;
            req_nxt   = 1'b0;
          end else begin
            pc_nxt    = target;
            req_nxt   = 1'b1;
            addr_nxt  = target;
            state_nxt = S_FETCH;
          end
        end else if (accept) begin
          valid_nxt = 1'b0;
          req_nxt   = 1'b1;
          addr_nxt  = pc;
          state_nxt = S_FETCH;
        end
      end

      S_HALT: begin
        valid_nxt = 1'b0;
        req_nxt   = 1'b0;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      pc        <= RESET_PC;
      acc_pc    <= RESET_PC;
      IMEM_REQ  <= 1'b0;
      IMEM_ADDR <= 32'h0;
      INSTR     <= 32'h0;
      INSTR_PC  <= 32'h0;
      VALID     <= 1'b0;
      MISALIGN  <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      acc_pc    <= acc_pc_nxt;
      IMEM_REQ  <= req_nxt;
      IMEM_ADDR <= addr_nxt;
      INSTR     <= instr_nxt;
      INSTR_PC  <= instr_pc_nxt;
      VALID     <= valid_nxt;
      MISALIGN  <= mis_nxt;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: imem and decode are driven cycle by cycle from one script.
module tb_fetch;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b1;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK = 1'b0;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic [31:0] INSTR;
  logic [31:0] INSTR_PC;
  logic        VALID;
  logic        NEXT_STALLED = 1'b0;
  logic        BRANCH = 1'b0;
  logic [11:0] BRANCH_IMM = 12'h0;
  logic        MISALIGN;

  int checks = 0;
  int errors = 0;

  fetch #(.RESET_PC(32'h0000_0000)) dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .IMEM_REQ     (IMEM_REQ),
    .IMEM_ADDR    (IMEM_ADDR),
    .IMEM_ACK     (IMEM_ACK),
    .IMEM_RDATA   (IMEM_RDATA),
    .INSTR        (INSTR),
    .INSTR_PC     (INSTR_PC),
    .VALID        (VALID),
    .NEXT_STALLED (NEXT_STALLED),
    .BRANCH       (BRANCH),
    .BRANCH_IMM   (BRANCH_IMM),
    .MISALIGN     (MISALIGN)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a + 32'h1300_0000;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, {31'h0, IMEM_REQ}, {31'h0, req});
    if (req) chk({tag, ".addr"}, IMEM_ADDR, addr);
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [31:0] ipc);
    chk({tag, ".valid"}, {31'h0, VALID}, {31'h0, vld});
    if (vld) begin
      chk({tag, ".instr_pc"}, INSTR_PC, ipc);
      chk({tag, ".instr"}, INSTR, word(ipc));
    end
  endtask

  task automatic ack(input logic [31:0] a);
    IMEM_ACK   = 1'b1;
    IMEM_RDATA = word(a);
    step();
    IMEM_ACK   = 1'b0;
    IMEM_RDATA = 32'h0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req"}, {31'h0, IMEM_REQ}, 32'h0);
    chk({tag, ".addr"}, IMEM_ADDR, 32'h0);
    chk({tag, ".instr"}, INSTR, 32'h0);
    chk({tag, ".instr_pc"}, INSTR_PC, 32'h0);
    chk({tag, ".valid"}, {31'h0, VALID}, 32'h0);
    chk({tag, ".misalign"}, {31'h0, MISALIGN}, 32'h0);
  endtask

  initial begin
    step();
    step();
    chk_reset("reset");

    // Sequential fetch 0x0, 0x4, 0x8 with no stall.
    RSTN = 1'b0;
    step();
    chk_req("seq_req0", 1'b1, 32'h0);
    ack(32'h0);
    chk_out("seq_out0", 1'b1, 32'h0);
    chk_req("seq_hold0", 1'b0, 32'h0);
    step();
    chk_out("seq_acc0", 1'b0, 32'h0);
    chk_req("seq_req4", 1'b1, 32'h4);
    ack(32'h4);
    chk_out("seq_out4", 1'b1, 32'h4);
    step();
    chk_req("seq_req8", 1'b1, 32'h8);
    ack(32'h8);
    chk_out("seq_out8", 1'b1, 32'h8);

    // Stall five cycles in HOLD.
    NEXT_STALLED = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("stall_out", 1'b1, 32'h8);
      chk_req("stall_req", 1'b0, 32'h0);
    end
    NEXT_STALLED = 1'b0;
    step();
    chk_out("unstall_out", 1'b0, 32'h0);
    chk_req("unstall_req", 1'b1, 32'hC);
    ack(32'hC);
    chk_out("out_c", 1'b1, 32'hC);

    // Redirect to 0x100 from ACC_PC=0x8 (imm 0x7C halfwords = 0xF8 bytes).
    NEXT_STALLED = 1'b1;
    BRANCH = 1'b1;
    BRANCH_IMM = 12'h07C;
    step();
    BRANCH = 1'b0;
    NEXT_STALLED = 1'b0;
    chk_out("br100_out", 1'b0, 32'h0);
    chk_req("br100_req", 1'b1, 32'h100);
    ack(32'h100);
    chk_out("out_100", 1'b1, 32'h100);
    step();
    chk_req("req_104", 1'b1, 32'h104);
    ack(32'h104);
    chk_out("out_104", 1'b1, 32'h104);

    // Held 0x104 squashed by redirect +0x10 from ACC_PC=0x100.
    NEXT_STALLED = 1'b1;
    BRANCH = 1'b1;
    BRANCH_IMM = 12'h008;
    step();
    BRANCH = 1'b0;
    NEXT_STALLED = 1'b0;
    chk_out("br110_out", 1'b0, 32'h0);
    chk_req("br110_req", 1'b1, 32'h110);
    ack(32'h110);
    chk_out("out_110", 1'b1, 32'h110);

    // ACC_PC is still 0x100 because 0x104 was never accepted: +0x100 -> 0x200.
    NEXT_STALLED = 1'b1;
    BRANCH = 1'b1;
    BRANCH_IMM = 12'h080;
    step();
    BRANCH = 1'b0;
    NEXT_STALLED = 1'b0;
    chk_req("br200_req", 1'b1, 32'h200);
    ack(32'h200);
    chk_out("out_200", 1'b1, 32'h200);
    step();
    chk_req("req_204", 1'b1, 32'h204);

    // Backward redirect -4 while 0x204 waits three cycles for ACK.
    BRANCH = 1'b1;
    BRANCH_IMM = 12'hFFE;
    step();
    BRANCH = 1'b0;
    chk_req("drop_w1", 1'b1, 32'h204);
    step();
    chk_req("drop_w2", 1'b1, 32'h204);
    step();
    chk_req("drop_w3", 1'b1, 32'h204);
    chk_out("drop_w3_out", 1'b0, 32'h0);
    ack(32'h204);
    chk_out("drop_discard", 1'b0, 32'h0);
    chk_req("drop_req1fc", 1'b1, 32'h1FC);
    ack(32'h1FC);
    chk_out("out_1fc", 1'b1, 32'h1FC);
    step();
    chk_req("req_200b", 1'b1, 32'h200);

    // ACK with BRANCH together, then two redirects inside the drop window.
    IMEM_ACK = 1'b1;
    IMEM_RDATA = word(32'h200);
    BRANCH = 1'b1;
    BRANCH_IMM = 12'h010;
    step();
    IMEM_ACK = 1'b0;
    IMEM_RDATA = 32'h0;
    chk_out("ackbr_out", 1'b0, 32'h0);
    chk_req("ackbr_req", 1'b1, 32'h21C);
    BRANCH_IMM = 12'h020;
    step();
    chk_req("drop2_a", 1'b1, 32'h21C);
    BRANCH_IMM = 12'h040;
    step();
    BRANCH = 1'b0;
    chk_req("drop2_b", 1'b1, 32'h21C);
    ack(32'h21C);
    chk_out("drop2_discard", 1'b0, 32'h0);
    chk_req("drop2_last", 1'b1, 32'h27C);
    ack(32'h27C);
    chk_out("out_27c", 1'b1, 32'h27C);
    step();
    chk_req("req_280", 1'b1, 32'h280);

    // Asynchronous reset while in the drop window.
    BRANCH = 1'b1;
    BRANCH_IMM = 12'h002;
    step();
    BRANCH = 1'b0;
    chk_req("pre_rst", 1'b1, 32'h280);
    #2;
    RSTN = 1'b1;
    #1;
    chk_reset("async_rst");
    step();
    RSTN = 1'b0;
    step();
    chk_req("rst_restart", 1'b1, 32'h0);
    ack(32'h0);
    chk_out("rst_out0", 1'b1, 32'h0);
    step();
    chk_req("rst_req4", 1'b1, 32'h4);
    ack(32'h4);
    chk_out("rst_out4", 1'b1, 32'h4);

    // Misaligned target 0x0 + 2 halts the stage permanently.
    NEXT_STALLED = 1'b1;
    BRANCH = 1'b1;
    BRANCH_IMM = 12'h001;
    step();
    BRANCH = 1'b0;
    NEXT_STALLED = 1'b0;
    chk("mis_flag", {31'h0, MISALIGN}, 32'h1);
    chk_out("mis_out", 1'b0, 32'h0);
    chk_req("mis_req", 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      BRANCH = 1'b1;
      BRANCH_IMM = 12'h010;
      IMEM_ACK = 1'b1;
      step();
      chk("halt_flag", {31'h0, MISALIGN}, 32'h1);
      chk_out("halt_out", 1'b0, 32'h0);
      chk_req("halt_req", 1'b0, 32'h0);
    end
    BRANCH = 1'b0;
    IMEM_ACK = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
